// File: rtl/control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit_if : IR opcode / zero flag in, datapath strobes out     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface control_unit_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] IRCU;
  logic           Zero;
  logic           IRload;
  logic           PCload;
  logic [1:0]     JSM;
  logic           Aload;
  logic           Bload;
  logic           ANSload;
  logic [1:0]     ALUop;
  logic           select_mode;
  logic           halted;

  // master = sequencer side, slave = datapath side
  modport master (
    input  IRCU, Zero,
    output IRload, PCload, JSM, Aload, Bload, ANSload, ALUop, select_mode, halted
  );

  modport slave (
    output IRCU, Zero,
    input  IRload, PCload, JSM, Aload, Bload, ANSload, ALUop, select_mode, halted
  );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit : FETCH -> LOAD -> EXEC sequencer driving CPU strobes   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module control_unit #(
  parameter int             OPW     = 4,
  parameter logic [OPW-1:0] HALT_OP = OPW'(15)
) (
  input  wire              Clk,
  input  wire              Reset,
  control_unit_if.master   bus
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    LOAD  = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [OPW-1:0] OP_LDA   = OPW'(1);
  localparam logic [OPW-1:0] OP_LDB   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5);
  localparam logic [OPW-1:0] OP_OR    = OPW'(6);
  localparam logic [OPW-1:0] OP_OUT   = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(8);
  localparam logic [OPW-1:0] OP_JZ    = OPW'(9);
  localparam logic [OPW-1:0] OP_JMODE = OPW'(10);

  state_t     state_q, state_d;
  logic       ir_load, pc_load, a_load, b_load, ans_load, sel_mode, halted;
  logic [1:0] jsm, alu_op;

  // Outputs decode from state_q alone outside EXEC, so async reset zeroes them at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    jsm      = 2'b00;
    a_load   = 1'b0;
    b_load   = 1'b0;
    ans_load = 1'b0;
    alu_op   = 2'b00;
    sel_mode = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_load = 1'b1;
        pc_load = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = (bus.IRCU == HALT_OP) ? HALT : FETCH;
        case (bus.IRCU)
          OP_LDA: a_load = 1'b1;
          OP_LDB: b_load = 1'b1;
          OP_ADD: begin ans_load = 1'b1; alu_op = 2'b00; end
          OP_SUB: begin ans_load = 1'b1; alu_op = 2'b01; end
          OP_AND: begin ans_load = 1'b1; alu_op = 2'b10; end
          OP_OR:  begin ans_load = 1'b1; alu_op = 2'b11; end
          OP_OUT: sel_mode = 1'b1;
          OP_JMP: begin pc_load = 1'b1; jsm = 2'b01; end
          OP_JZ: begin
            pc_load = bus.Zero;
            jsm     = bus.Zero ? 2'b01 : 2'b00;
          end
          OP_JMODE: begin pc_load = 1'b1; jsm = 2'b10; end
          default: ;
        endcase
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  assign bus.IRload      = ir_load;
  assign bus.PCload      = pc_load;
  assign bus.JSM         = jsm;
  assign bus.Aload       = a_load;
  assign bus.Bload       = b_load;
  assign bus.ANSload     = ans_load;
  assign bus.ALUop       = alu_op;
  assign bus.select_mode = sel_mode;
  assign bus.halted      = halted;

endmodule
`default_nettype wire
